// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// imem_pkg : shared state encoding and constants for the instruction responder
// Rev 1.0
// ============================================================================
package imem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_wait = 2'd1;
  localparam state_t c_st_resp = 2'd2;

  localparam int unsigned c_lat_default = 2;
  localparam logic [15:0] c_err_data    = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// imem_array : 16-bit word storage, one synchronous write, one async read port
// Rev 1.0
// ============================================================================
module imem_array #(
  parameter int unsigned DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [15:0]        wdata_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [15:0]        rdata_o
);

  // Contents are deliberately left out of reset so a preload survives it.
  logic [15:0] mem_q [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// imem_responder : single-outstanding instruction fetch responder with fixed
//                  latency, misalignment error, flush and consumer back-pressure
// Rev 1.0
// ============================================================================
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned LAT     = c_lat_default,
  parameter int unsigned DEPTH_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam logic [1:0] c_cnt_load = 2'(LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [15:0] data_q,  data_d;
  logic        err_q,   err_d;

  logic        w_accept;
  logic [15:0] w_rd_data;
  logic        w_unused;

  // Upper address bits are dropped so addresses wrap within the storage.
  assign w_unused = ^{req_addr, ld_addr};

  imem_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ld_en),
    .waddr_i (ld_addr[DEPTH_W:1]),
    .wdata_i (ld_data),
    .raddr_i (req_addr[DEPTH_W:1]),
    .rdata_o (w_rd_data)
  );

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      c_st_idle: begin
        // Data is snapshotted here, so later loads cannot disturb the reply.
        if (w_accept) begin
          data_d  = req_addr[0] ? c_err_data : w_rd_data;
          err_d   = req_addr[0];
          cnt_d   = c_cnt_load;
          state_d = (LAT > 1) ? c_st_wait : c_st_resp;
        end
      end
      c_st_wait: begin
        if (flush) begin
          state_d = c_st_idle;
          cnt_d   = '0;
        end else if (cnt_q <= 2'd1) begin
          state_d = c_st_resp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      c_st_resp: begin
        if (flush || rsp_ready) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready = (state_q == c_st_idle) && !flush;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (state_q == c_st_resp) begin
      rsp_valid = 1'b1;
      rsp_data  = data_q;
      rsp_err   = err_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// tb_imem_responder : directed scenarios plus randomized traffic against a
//                     word-array reference model
// Rev 1.0
// ============================================================================
module tb_imem_responder;

  localparam int unsigned LAT     = 2;
  localparam int unsigned DEPTH_W = 10;
  localparam int          NWORDS  = 1 << DEPTH_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr  = '0;
  logic        req_ready;
  logic        flush     = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready = 1'b0;
  logic        ld_en     = 1'b0;
  logic [15:0] ld_addr   = '0;
  logic [15:0] ld_data   = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [NWORDS];

  imem_responder #(
    .LAT     (LAT),
    .DEPTH_W (DEPTH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % NWORDS;
  endfunction

  function automatic logic [15:0] exp_data(input logic [15:0] a);
    return a[0] ? 16'h0000 : ref_mem[widx(a)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    ref_mem[widx(a)] = d;
  endtask

  // ld_at: -1 no load, 0 load same word in the accept cycle, 1 load it in the wait cycle
  task automatic run_req(input logic [15:0] a, input int stall, input int ld_at,
                         input logic [15:0] ld_d, input string tag);
    logic [15:0] ed;
    logic        ee;
    logic [15:0] la;
    ed = exp_data(a);
    ee = a[0];
    la = (a ^ 16'h0800) & 16'hFFFE;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
    if (ld_at == 0) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_ready: req_ready=%b expected 1", tag, req_ready);
    end
    tick();
    req_valid = 1'b0;
    if (ld_at == 0) begin ld_en = 1'b0; ref_mem[widx(la)] = ld_d; end
    for (int k = 1; k < LAT; k++) begin
      if (ld_at == 1 && k == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL %s early_rsp: rsp_valid=%b expected 0 at cycle %0d", tag, rsp_valid, k);
      end
      tick();
      if (ld_at == 1 && k == 1) begin ld_en = 1'b0; ref_mem[widx(la)] = ld_d; end
    end
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== ee) begin
        errors++;
        $display("FAIL %s rsp: valid=%b data=%h err=%b expected valid=1 data=%h err=%b (stall %0d)",
                 tag, rsp_valid, rsp_data, rsp_err, ed, ee, s);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_ready: req_ready=%b expected 0", tag, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: rsp_valid=%b req_ready=%b expected 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic expect_quiet(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL %s quiet: valid=%b data=%h err=%b expected 0/0000/0", tag, rsp_valid, rsp_data, rsp_err);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h err=%b expected 0/0000/0", rsp_valid, rsp_data, rsp_err);
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) load(16'(i * 2), 16'($urandom));
    load(16'h0004, 16'hA5C3);
    load(16'h0010, 16'h5A3C);
  endtask

  task automatic test_normal_read();
    run_req(16'h0004, 0, -1, 16'h0, "normal");
    run_req(16'hF804, 0, -1, 16'h0, "wrap");
  endtask

  task automatic test_misaligned();
    run_req(16'h0007, 0, -1, 16'h0, "misaligned");
  endtask

  task automatic test_stall();
    run_req(16'h0004, 3, -1, 16'h0, "stall");
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_addr = 16'h0004;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_wait: req_ready=%b rsp_valid=%b expected 0/0", req_ready, rsp_valid);
    end
    tick();
    flush = 1'b0;
    expect_quiet(1, "flush_wait");
    run_req(16'h0010, 0, -1, 16'h0, "after_flush");
  endtask

  task automatic test_flush_resp();
    req_valid = 1'b1; req_addr = 16'h0010;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL flush_resp_pre: rsp_valid=%b expected 1", rsp_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_quiet(LAT + 1, "flush_resp");
  endtask

  task automatic test_flush_idle();
    flush = 1'b1; req_valid = 1'b1; req_addr = 16'h0004;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready: req_ready=%b expected 0", req_ready);
    end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    expect_quiet(LAT + 1, "flush_idle");
  endtask

  task automatic test_load_collision();
    run_req(16'h0004, 0, 0, 16'h1111, "collision");
    run_req(16'h0004, 0, -1, 16'h0, "collision_after");
    checks++;
    if (ref_mem[2] !== 16'h1111) begin
      errors++; $display("FAIL collision_model: ref=%h expected 1111", ref_mem[2]);
    end
  endtask

  task automatic test_reset_in_resp();
    req_valid = 1'b1; req_addr = 16'h0004;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin
      errors++; $display("FAIL reset_async: rsp_valid=%b data=%h expected 0/0000", rsp_valid, rsp_data);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL reset_stale: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
      end
      tick();
    end
    run_req(16'h0004, 0, -1, 16'h0, "retained");
  endtask

  task automatic test_random();
    logic [15:0] a;
    int          r;
    for (int i = 0; i < 40; i++) begin
      a = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 63) << 1));
      if ($urandom_range(0, 4) == 0) a[0] = 1'b1;
      r = int'($urandom_range(0, 2)) - 1;
      run_req(a, int'($urandom_range(0, 3)), r, 16'($urandom), "random");
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_normal_read();
    test_misaligned();
    test_stall();
    test_flush();
    test_flush_resp();
    test_flush_idle();
    test_load_collision();
    test_reset_in_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
